// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - record types and beat formatting for the commit trace transmitter
package commit_trace_pkg;

  localparam int PC_W     = 40;
  localparam int NR_SLOTS = 3;
  localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;

  typedef enum logic [7:0] {
    COMMIT    = 8'h01,
    EXCEPTION = 8'h02
  } rec_type_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_GPR  = 2'd1,
    RD_FPR  = 2'd2,
    RD_POSR = 2'd3
  } rd_kind_e;

  // For exception records {ts, instr} carries the 64-bit cause and payload carries tval,
  // so beat1/beat2 are formed identically for both record types.
  typedef struct packed {
    rec_type_e        rtype;
    logic [1:0]       priv;
    logic             debug;
    rd_kind_e         rd_kind;
    logic [4:0]       rd;
    logic [PC_W-1:0]  pc;
    logic [31:0]      instr;
    logic [31:0]      ts;
    logic [63:0]      payload;
  } trace_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_B0,
    ST_B1,
    ST_B2
  } ser_state_e;

  function automatic logic [63:0] beat_of(input trace_rec_t rec, input logic [1:0] idx);
    case (idx)
      2'd0:    return {rec.rtype, rec.priv, rec.debug, rec.rd_kind, rec.rd, 6'b0, rec.pc};
      2'd1:    return {rec.ts, rec.instr};
      default: return rec.payload;
    endcase
  endfunction

endpackage

// File: rtl/riscv.sv
// rtl/riscv.sv - minimal riscv package slice: virtual address width and privilege levels
package riscv;

  localparam int VLEN = 39;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

endpackage

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - record FIFO with up to three pushes and one pop per cycle
module commit_trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 push_cnt_i,
  input  trace_rec_t [NR_SLOTS-1:0]  push_data_i,
  input  logic                       pop_i,
  output logic [CNT_W-1:0]           free_o,
  output logic                       nonempty_next_o,
  output trace_rec_t                 head_next_o
);

  trace_rec_t        mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  bypass_off;

  // Next pointers and occupancy; the caller never pushes past the free space or pops when empty.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_cnt_i);
    rptr_d  = rptr_q + PTR_W'(pop_i);
    count_d = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage: pushes land in consecutive slots starting at the write pointer.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_SLOTS; i++) begin
      if (2'(i) < push_cnt_i) begin
        mem_q[wptr_q + PTR_W'(i)] <= push_data_i[i];
      end
    end
  end

  // Head as it will be after this edge, forwarding a record that is being written into that slot.
  always_comb begin
    bypass_off  = rptr_d - wptr_q;
    head_next_o = mem_q[rptr_d];
    for (int i = 0; i < NR_SLOTS; i++) begin
      if (bypass_off == PTR_W'(i) && 2'(i) < push_cnt_i) begin
        head_next_o = push_data_i[i];
      end
    end
  end

  assign free_o          = CNT_W'(DEPTH) - count_q;
  assign nonempty_next_o = (count_d != '0);

endmodule

// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - commit/exception trace capture and 64-bit beat serializer (option: COMMIT_TRACE_TS_EN)
module commit_trace_tx
  import commit_trace_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        enable_i,
  input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0][riscv::VLEN-1:0] commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0][31:0]            commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0][1:0]             commit_rd_kind_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]             commit_waddr_i,
  input  logic [NR_COMMIT_PORTS-1:0][63:0]            commit_wdata_i,
  input  riscv::priv_lvl_t                            priv_lvl_i,
  input  logic                                        debug_mode_i,
  input  logic                                        ex_valid_i,
  input  logic [63:0]                                 ex_cause_i,
  input  logic [63:0]                                 ex_tval_i,
  output logic                                        trace_valid_o,
  output logic [63:0]                                 trace_data_o,
  output logic                                        trace_last_o,
  input  logic                                        trace_ready_i,
  output logic [15:0]                                 drop_cnt_o,
  output logic                                        overflow_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]               ts_now;
  trace_rec_t [1:0]          rec_c;
  trace_rec_t                rec_ex;
  trace_rec_t [NR_SLOTS-1:0] slot;
  logic                      want_c0, want_c1, want_ex;
  logic [1:0]                n_rec;
  logic                      admit;
  logic [1:0]                push_cnt;
  logic [CNT_W-1:0]          fifo_free;
  logic                      fifo_nonempty_next;
  trace_rec_t                head_next;
  logic                      pop;
  logic                      hs;
  logic [16:0]               drop_sum;
  logic [15:0]               drop_cnt_q, drop_cnt_d;
  logic                      overflow_q;
  ser_state_e                state_q, state_d;
  logic [1:0]                beat_idx;
  logic                      valid_q, valid_d;
  logic [63:0]               data_q, data_d;
  logic                      last_q, last_d;

`ifdef COMMIT_TRACE_TS_EN
  logic [31:0] ts_q;

  // Free-running cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end

  assign ts_now = ts_q;
`else
  assign ts_now = '0;
`endif

  // Build the candidate records for this cycle and compact them into push order.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rec_c[p].rtype   = COMMIT;
      rec_c[p].priv    = priv_lvl_i;
      rec_c[p].debug   = debug_mode_i;
      rec_c[p].rd_kind = rd_kind_e'(commit_rd_kind_i[p]);
      rec_c[p].rd      = commit_waddr_i[p];
      rec_c[p].pc      = PC_W'(commit_pc_i[p]);
      rec_c[p].instr   = commit_instr_i[p];
      rec_c[p].ts      = ts_now;
      rec_c[p].payload = (commit_rd_kind_i[p] == 2'd0) ? 64'd0 : commit_wdata_i[p];
    end
    rec_ex.rtype   = EXCEPTION;
    rec_ex.priv    = priv_lvl_i;
    rec_ex.debug   = debug_mode_i;
    rec_ex.rd_kind = RD_NONE;
    rec_ex.rd      = 5'd0;
    rec_ex.pc      = PC_W'(commit_pc_i[0]);
    rec_ex.ts      = ex_cause_i[63:32];
    rec_ex.instr   = ex_cause_i[31:0];
    rec_ex.payload = ex_tval_i;

    want_c0 = enable_i & commit_ack_i[0];
    want_c1 = enable_i & commit_ack_i[1];
    want_ex = enable_i & ex_valid_i & ~(debug_mode_i & (ex_cause_i == CAUSE_BREAKPOINT));
    n_rec   = 2'(want_c0) + 2'(want_c1) + 2'(want_ex);

    slot[0] = want_c0 ? rec_c[0] : (want_c1 ? rec_c[1] : rec_ex);
    slot[1] = (want_c0 && want_c1) ? rec_c[1] : rec_ex;
    slot[2] = rec_ex;

    // All-or-nothing admission against the registered free count.
    admit    = (CNT_W'(n_rec) <= fifo_free);
    push_cnt = admit ? n_rec : 2'd0;

    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_rec);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  commit_trace_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .push_cnt_i      (push_cnt),
    .push_data_i     (slot),
    .pop_i           (pop),
    .free_o          (fifo_free),
    .nonempty_next_o (fifo_nonempty_next),
    .head_next_o     (head_next)
  );

  // Drop counter saturates; overflow flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (!admit) begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= 1'b1;
    end
  end

  assign hs = valid_q & trace_ready_i;

  // Serializer next state; the record is popped on acceptance of its last beat.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: if (fifo_nonempty_next) state_d = ST_B0;
      ST_B0:   if (hs) state_d = ST_B1;
      ST_B1:   if (hs) state_d = ST_B2;
      ST_B2: begin
        if (hs) begin
          pop     = 1'b1;
          state_d = fifo_nonempty_next ? ST_B0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output registers are loaded from the upcoming state so beat0 can appear the cycle after capture.
    beat_idx = (state_d == ST_B1) ? 2'd1 : ((state_d == ST_B2) ? 2'd2 : 2'd0);
    valid_d  = (state_d != ST_IDLE);
    last_d   = (state_d == ST_B2);
    data_d   = valid_d ? beat_of(head_next, beat_idx) : 64'd0;
  end

  // State and registered stream outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign trace_valid_o = valid_q;
  assign trace_data_o  = data_q;
  assign trace_last_o  = last_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// tb/tb_commit_trace_tx.sv - self-checking bench for commit_trace_tx with a record-level reference model
module tb_commit_trace_tx;

  localparam int DEPTH = 8;
  localparam int VL    = riscv::VLEN;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                dbg;
  logic                exv;
  logic                ready;
  logic [1:0]          ack;
  logic [1:0][VL-1:0]  pc;
  logic [1:0][31:0]    instr;
  logic [1:0][1:0]     rdk;
  logic [1:0][4:0]     waddr;
  logic [1:0][63:0]    wdata;
  riscv::priv_lvl_t    priv;
  logic [63:0]         cause;
  logic [63:0]         tval;
  logic                t_valid;
  logic [63:0]         t_data;
  logic                t_last;
  logic [15:0]         drop_cnt;
  logic                ovf;

  always #5 clk = ~clk;

  commit_trace_tx #(
    .NR_COMMIT_PORTS (2),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .commit_ack_i     (ack),
    .commit_pc_i      (pc),
    .commit_instr_i   (instr),
    .commit_rd_kind_i (rdk),
    .commit_waddr_i   (waddr),
    .commit_wdata_i   (wdata),
    .priv_lvl_i       (priv),
    .debug_mode_i     (dbg),
    .ex_valid_i       (exv),
    .ex_cause_i       (cause),
    .ex_tval_i        (tval),
    .trace_valid_o    (t_valid),
    .trace_data_o     (t_data),
    .trace_last_o     (t_last),
    .trace_ready_i    (ready),
    .drop_cnt_o       (drop_cnt),
    .overflow_o       (ovf)
  );

  int total = 0;
  int bad   = 0;

  // Beats accepted by the receiver, captured mid-cycle.
  logic [64:0] obs_mem [4096];
  int          obs_wr = 0;
  int          popped = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && t_valid === 1'b1 && ready === 1'b1) begin
      obs_mem[obs_wr % 4096] <= {t_last, t_data};
      obs_wr <= obs_wr + 1;
      if (t_last) popped <= popped + 1;
    end
  end

`ifdef COMMIT_TRACE_TS_EN
  logic [31:0] cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end
`endif

  // Reference model state: expected beats {last, data}, records in flight, drop bookkeeping.
  logic [64:0] exp_q [$];
  int          obs_rd;
  int          pushed_recs;
  int          popped_base;
  int          m_drop;
  logic        m_ovf;

  function automatic logic [31:0] ts_exp();
`ifdef COMMIT_TRACE_TS_EN
    return cyc;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Applies the capture rules to the inputs currently driven for this cycle.
  task automatic model_cycle();
    logic [64:0] recs [$];
    int n;
    int free;
    n = 0;
    if (enable) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          recs.push_back({1'b0, 8'h01, 2'(priv), dbg, rdk[p], waddr[p], 6'b0, 40'(pc[p])});
          recs.push_back({1'b0, ts_exp(), instr[p]});
          recs.push_back({1'b1, (rdk[p] == 2'd0) ? 64'd0 : wdata[p]});
          n++;
        end
      end
      if (exv && !(dbg && cause == 64'd3)) begin
        recs.push_back({1'b0, 8'h02, 2'(priv), dbg, 2'b00, 5'd0, 6'b0, 40'(pc[0])});
        recs.push_back({1'b0, cause});
        recs.push_back({1'b1, tval});
        n++;
      end
    end
    free = DEPTH - (pushed_recs - (popped - popped_base));
    if (n <= free) begin
      foreach (recs[i]) exp_q.push_back(recs[i]);
      pushed_recs += n;
    end else begin
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
      m_ovf  = 1'b1;
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ack = 2'b00;
    exv = 1'b0;
  endtask

  task automatic randomize_fields();
    for (int p = 0; p < 2; p++) begin
      pc[p]    = VL'({$urandom(), $urandom()});
      instr[p] = $urandom();
      rdk[p]   = 2'($urandom());
      waddr[p] = 5'($urandom());
      wdata[p] = {$urandom(), $urandom()};
    end
    cause = {$urandom(), $urandom()};
    tval  = {$urandom(), $urandom()};
  endtask

  task automatic drain(input string tag, input int budget);
    int waited;
    int avail;
    logic [64:0] o;
    waited = 0;
    clear_events();
    ready = 1'b1;
    while ((obs_wr - obs_rd) < exp_q.size() && waited < budget) begin
      step();
      waited++;
    end
    avail = obs_wr - obs_rd;
    check({tag, "_beats"}, 64'(avail), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < avail) begin
        o = obs_mem[(obs_rd + i) % 4096];
        check($sformatf("%s_data%0d", tag, i), o[63:0], exp_q[i][63:0]);
        check($sformatf("%s_last%0d", tag, i), 64'(o[64]), 64'(exp_q[i][64]));
      end
    end
    obs_rd = obs_rd + avail;
    exp_q.delete();
    check({tag, "_idle"}, 64'(t_valid), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pushed_recs = 0;
    popped_base = popped;
    obs_rd      = obs_wr;
    m_drop      = 0;
    m_ovf       = 1'b0;
  endtask

  initial begin
    logic [63:0] held_d;
    logic        held_l;

    rst_n  = 1'b0;
    enable = 1'b1;
    ready  = 1'b0;
    dbg    = 1'b0;
    priv   = riscv::PRIV_LVL_M;
    clear_events();
    randomize_fields();
    obs_rd      = 0;
    pushed_recs = 0;
    popped_base = 0;
    m_drop      = 0;
    m_ovf       = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(t_valid), 64'd0);
    check("rst_data", t_data, 64'd0);
    check("rst_last", 64'(t_last), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    step();

    // Single port-0 commit: beat0 visible the next cycle, three consecutive beats.
    ready    = 1'b1;
    ack      = 2'b01;
    pc[0]    = VL'(64'h8000_0000);
    instr[0] = 32'h00A0_0513;
    rdk[0]   = 2'd1;
    waddr[0] = 5'd10;
    wdata[0] = 64'd10;
    step();
    clear_events();
    #3;
    check("t1_latency_valid", 64'(t_valid), 64'd1);
    check("t1_b0_kind_rd", 64'(t_data[52:46]), 64'(7'b01_01010));
    check("t1_b0_last", 64'(t_last), 64'd0);
    step();
    step();
    step();
    check("t1_consecutive", 64'(obs_wr - obs_rd), 64'd3);
    drain("t1", 20);

    // Two commits plus an exception in one cycle.
    randomize_fields();
    ack   = 2'b11;
    exv   = 1'b1;
    cause = 64'd2;
    priv  = riscv::PRIV_LVL_S;
    step();
    drain("t2", 40);

    // Receiver stalls for five cycles while beat1 is presented.
    randomize_fields();
    ack = 2'b01;
    step();
    clear_events();
    step();
    ready  = 1'b0;
    held_d = t_data;
    held_l = t_last;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("t3_hold_data%0d", k), t_data, held_d);
      check($sformatf("t3_hold_last%0d", k), 64'(t_last), 64'(held_l));
      check($sformatf("t3_hold_valid%0d", k), 64'(t_valid), 64'd1);
    end
    check("t3_no_extra", 64'(obs_wr - obs_rd), 64'd1);
    drain("t3", 40);

    // Fill to 7 of 8 with the receiver stalled, then a two-commit cycle must be dropped whole.
    ready = 1'b0;
    randomize_fields();
    ack = 2'b11;
    step();
    randomize_fields();
    ack   = 2'b11;
    exv   = 1'b1;
    cause = 64'd8;
    step();
    clear_events();
    randomize_fields();
    ack = 2'b11;
    step();
    randomize_fields();
    ack = 2'b11;
    step();
    clear_events();
    check("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    check("t4_overflow", 64'(ovf), 64'd1);
    drain("t4", 100);

    // Breakpoint taken in debug mode is not traced; an ecall is.
    dbg   = 1'b1;
    exv   = 1'b1;
    cause = 64'd3;
    step();
    clear_events();
    dbg = 1'b0;
    repeat (3) step();
    check("t5_bkpt_valid", 64'(t_valid), 64'd0);
    check("t5_bkpt_beats", 64'(obs_wr - obs_rd), 64'd0);
    randomize_fields();
    exv   = 1'b1;
    cause = 64'd8;
    step();
    drain("t5", 40);

    // Random traffic with a throttled receiver.
    for (int c = 0; c < 150; c++) begin
      randomize_fields();
      ack = 2'($urandom());
      exv = ($urandom_range(0, 3) == 0);
      dbg = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       cause = 64'd3;
        1:       cause = 64'd8;
        default: cause = {$urandom(), $urandom()};
      endcase
      case ($urandom_range(0, 2))
        0:       priv = riscv::PRIV_LVL_U;
        1:       priv = riscv::PRIV_LVL_S;
        default: priv = riscv::PRIV_LVL_M;
      endcase
      enable = ($urandom_range(0, 7) != 0);
      ready  = ($urandom_range(0, 1) == 1);
      step();
    end
    enable = 1'b1;
    dbg    = 1'b0;
    drain("t6", 1000);
    check("t6_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("t6_overflow", 64'(ovf), 64'(m_ovf));

    // Reset asserted while beat1 is presented aborts everything immediately.
    randomize_fields();
    ack = 2'b01;
    step();
    clear_events();
    step();
    ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_rst_valid", 64'(t_valid), 64'd0);
    check("t7_rst_data", t_data, 64'd0);
    check("t7_rst_last", 64'(t_last), 64'd0);
    check("t7_rst_drop", 64'(drop_cnt), 64'd0);
    check("t7_rst_ovf", 64'(ovf), 64'd0);
    model_reset();
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    randomize_fields();
    ack = 2'b10;
    step();
    clear_events();
    #3;
    check("t7_fresh_valid", 64'(t_valid), 64'd1);
    drain("t7", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_tx.md
# commit_trace_tx

Synthesizable commit-trace transmitter. Captures per-cycle commit and exception events from the commit stage, buffers them as fixed-size records, and streams them out as 64-bit beats over a valid/ready interface. It is the hardware-side producer for off-core trace receivers, so runs can be logged on FPGA/silicon without a simulation tracer.

## Interface
- NR_COMMIT_PORTS, 2: commit ports sampled per cycle; fixed at 2 in this revision.
- FIFO_DEPTH, 8: record FIFO depth; power of 2, at least 4.
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  capture enable; when 0 nothing is enqueued and already-buffered records still drain
- commit_ack_i  in  2  per-port commit strobe
- commit_pc_i  in  2x riscv::VLEN  committed PC
- commit_instr_i  in  2x32  raw instruction word
- commit_rd_kind_i  in  2x2  destination kind: 0 none, 1 GPR, 2 FPR, 3 POSR
- commit_waddr_i  in  2x5  destination register
- commit_wdata_i  in  2x64  write-back value
- priv_lvl_i  in  riscv::priv_lvl_t  current privilege
- debug_mode_i  in  1  core in debug mode
- ex_valid_i  in  1  exception taken this cycle
- ex_cause_i  in  64  exception cause
- ex_tval_i  in  64  exception tval
- trace_valid_o  out  1  beat valid
- trace_data_o  out  64  beat payload
- trace_last_o  out  1  last beat of record
- trace_ready_i  in  1  downstream accept
- drop_cnt_o  out  16  records dropped; saturates at 0xFFFF
- overflow_o  out  1  sticky: at least one drop since reset

## Operation
- Records per cycle, enqueued in this order: port 0 commit, port 1 commit, exception. Maximum 3 records per cycle.
- Commit record (type 0x01), 3 beats:
  - beat0: [63:56] type, [55:54] priv, [53] debug, [52:51] rd_kind, [50:46] rd, [45:40] 0, [39:0] zero-extended pc
  - beat1: [63:32] timestamp, [31:0] instr
  - beat2: wdata; 0 when rd_kind = 0
- Exception record (type 0x02), 3 beats:
  - beat0: same layout as commit beat0 with rd_kind = 0 and rd = 0; pc is commit_pc_i[0]
  - beat1: cause
  - beat2: tval
- Exceptions with debug_mode_i = 1 and cause = BREAKPOINT are not recorded.
- Admission is atomic per cycle. Let n be the number of records this cycle and free = FIFO_DEPTH − count, where count is the registered count; a pop in the same cycle is not credited.
  - If n ≤ free, all n records are enqueued.
  - Otherwise none are enqueued, drop_cnt_o increases by n (saturating), and overflow_o is set.
- Serializer FSM:
  - IDLE → B0 when the FIFO is non-empty.
  - B0 → B1 → B2, each advancing on trace_valid_o && trace_ready_i.
  - On B2 accept the head record is popped; go to B0 if the FIFO is still non-empty, otherwise IDLE.
- trace_last_o = 1 only in B2. trace_valid_o = 1 in B0, B1 and B2.

## Timing
- Reset values: trace_valid_o = 0, trace_data_o = 0, trace_last_o = 0, drop_cnt_o = 0, overflow_o = 0. FIFO is empty, FSM is in IDLE, timestamp is 0.
- A reset asserted mid-record aborts the record immediately; there is no partial-record recovery.
- Latency: events in cycle N give beat0 valid at N+1 at the earliest, when the FIFO was empty and the FSM was in IDLE.
- trace_data_o and trace_last_o are registered and must stay stable while trace_valid_o && !trace_ready_i. trace_valid_o never drops without a handshake.
- Full-rate throughput is one beat per cycle. A sustained 3-record cycle needs 9 beats to drain.
- Simultaneous enqueue and pop in the same cycle: count changes by (pushes − 1).
- Timestamp is a 32-bit free-running cycle counter that wraps 0xFFFFFFFF → 0. Each record carries the value sampled in its capture cycle.

## Configuration
- COMMIT_TRACE_TS_EN
  - Defined: timestamp counter is instantiated and beat1[63:32] carries it.
  - Undefined: the counter is absent and beat1[63:32] = 0.

## Structure
- commit_trace_pkg holds:
  - rec_type_e (COMMIT = 8'h01, EXCEPTION = 8'h02)
  - rd_kind_e
  - trace_rec_t: type, priv, debug, rd_kind, rd, pc, instr, ts, payload
  - function beat_of(trace_rec_t, idx) returning the 64-bit beat
- Sub-module commit_trace_fifo: up to 3 pushes and 1 pop per cycle, registered count, exposes free.
- Top level contains admission logic, drop counter, FSM and output registers.

## Test plan
- Single commit, port 0: pc = 0x8000_0000, instr = 0x00A00513, GPR x10, wdata = 10, ready held 1 → three beats on consecutive cycles starting N+1; beat0[52:46] = {2'b01, 5'd10}; last only on beat2.
- Dual commit plus exception in one cycle, ready = 1 → 9 beats in order port0, port1, exception; exception beat1 = cause, beat2 = tval.
- ready held 0 for 5 cycles during beat1 → data and last unchanged; no extra pop; stream resumes correctly.
- Fill FIFO to 7 of 8, then a 2-commit cycle → nothing enqueued, drop_cnt_o = 2, overflow_o = 1; stream contents unchanged.
- Debug-mode breakpoint exception → no record; a normal ecall (cause 8) → exception record emitted.
- Assert rst_ni mid-beat1 → all outputs reset asynchronously; after release, a new commit streams with a fresh beat0.
